// File: rtl/i2c_slave_core.sv
// i2c_slave_core: 7-bit addressed I2C slave in front of an 8x8 register file.
// Writes: [addr+W] [ptr] [data]*, each data byte lands at reg[ptr] and ptr
// auto-increments mod 8. Reads: [addr+R] streams reg[ptr], reg[ptr+1], ...
// until the master NACKs. No clock stretching; SDA is open-drain via sda_oe_o.
//
// Ports
//   i2c_core_clock_i    core clock, >= 16x SCL
//   i2c_core_reset_n_i  synchronous active-low reset
//   scl_i, sda_i        asynchronous bus levels
//   sda_oe_o            1 = pull SDA low
//   busy_o              addressed: from address match until STOP/START
//   wr_valid_o          one-cycle pulse per register write
//   wr_addr_o/wr_data_o index/data of the current write pulse
module i2c_slave_core #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i2c_core_clock_i,
  input  logic       i2c_core_reset_n_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       busy_o,
  output logic       wr_valid_o,
  output logic [2:0] wr_addr_o,
  output logic [7:0] wr_data_o
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned PTR_W    = 3;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] rx_shift, rx_nxt;
  logic [DATA_W-2:0] tx_rest, tx_nxt;   // bits of the read byte not yet driven
  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic              mack, mack_nxt;    // master ACK captured during RD_ACK
  logic              sda_oe_nxt, busy_nxt, wr_valid_nxt, reg_we;
  logic [PTR_W-1:0]  wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd_byte;
  logic              bit_done, addr_match;

  // Bus synchronizers and one-cycle-delayed copies for edge detection
  always_ff @(posedge i2c_core_clock_i) begin
    if (!i2c_core_reset_n_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SDA edges only count as conditions while SCL is stably high
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign bit_done   = (bit_cnt == CNT_W'(8));
  assign addr_match = (rx_shift[7:1] == SLAVE_ADDR);
  assign rd_byte    = regs[ptr];

  // State register
  always_ff @(posedge i2c_core_clock_i) begin
    if (!i2c_core_reset_n_i) state <= IDLE;
    else                     state <= state_nxt;
  end

  // Next-state logic; STOP outranks START, then byte/ACK boundaries on SCL fall
  always_comb begin
    state_nxt = state;
    if (stop_det) begin
      state_nxt = IDLE;
    end else if (start_det) begin
      state_nxt = ADDR;
    end else if (scl_fall) begin
      case (state)
        ADDR:     if (bit_done) state_nxt = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: state_nxt = rx_shift[0] ? RD_DATA : PTR;
        PTR:      if (bit_done) state_nxt = PTR_ACK;
        PTR_ACK:  state_nxt = WR_DATA;
        WR_DATA:  if (bit_done) state_nxt = WR_ACK;
        WR_ACK:   state_nxt = WR_DATA;
        RD_DATA:  if (bit_done) state_nxt = RD_ACK;
        RD_ACK:   state_nxt = mack ? RD_DATA : IGNORE;
        default:  state_nxt = state;
      endcase
    end
  end

  // Output/datapath next values; SDA drive only moves on an SCL fall
  always_comb begin
    sda_oe_nxt   = sda_oe_o;
    busy_nxt     = busy_o;
    wr_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr_o;
    wr_data_nxt  = wr_data_o;
    bit_cnt_nxt  = bit_cnt;
    rx_nxt       = rx_shift;
    tx_nxt       = tx_rest;
    ptr_nxt      = ptr;
    mack_nxt     = mack;
    reg_we       = 1'b0;
    if (stop_det || start_det) begin
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = '0;
    end else if (scl_rise) begin
      if ((state inside {ADDR, PTR, WR_DATA, RD_DATA}) && !bit_done) begin
        rx_nxt      = {rx_shift[DATA_W-2:0], sda_s};
        bit_cnt_nxt = bit_cnt + CNT_W'(1);
      end
      if (state == RD_ACK) mack_nxt = ~sda_s;
    end else if (scl_fall) begin
      case (state)
        ADDR: begin
          if (bit_done && addr_match) begin
            sda_oe_nxt = 1'b1;
            busy_nxt   = 1'b1;
          end
        end
        ADDR_ACK: begin
          bit_cnt_nxt = '0;
          sda_oe_nxt  = 1'b0;
          if (rx_shift[0]) begin
            tx_nxt     = rd_byte[DATA_W-2:0];
            sda_oe_nxt = ~rd_byte[DATA_W-1];
          end
        end
        PTR: begin
          if (bit_done) begin
            ptr_nxt    = rx_shift[PTR_W-1:0];
            sda_oe_nxt = 1'b1;
          end
        end
        WR_DATA: begin
          if (bit_done) begin
            reg_we       = 1'b1;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = ptr;
            wr_data_nxt  = rx_shift;
            ptr_nxt      = ptr + PTR_W'(1);
            sda_oe_nxt   = 1'b1;
          end
        end
        PTR_ACK, WR_ACK: begin
          bit_cnt_nxt = '0;
          sda_oe_nxt  = 1'b0;
        end
        RD_DATA: begin
          if (bit_done) begin
            sda_oe_nxt = 1'b0;
            ptr_nxt    = ptr + PTR_W'(1);
          end else if (bit_cnt != '0) begin
            sda_oe_nxt = ~tx_rest[DATA_W-2];
            tx_nxt     = {tx_rest[DATA_W-3:0], 1'b0};
          end
        end
        RD_ACK: begin
          bit_cnt_nxt = '0;
          sda_oe_nxt  = 1'b0;
          if (mack) begin
            tx_nxt     = rd_byte[DATA_W-2:0];
            sda_oe_nxt = ~rd_byte[DATA_W-1];
          end
        end
        default: sda_oe_nxt = 1'b0;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge i2c_core_clock_i) begin
    if (!i2c_core_reset_n_i) begin
      sda_oe_o   <= 1'b0;
      busy_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_rest    <= '0;
      ptr        <= '0;
      mack       <= 1'b0;
    end else begin
      sda_oe_o   <= sda_oe_nxt;
      busy_o     <= busy_nxt;
      wr_valid_o <= wr_valid_nxt;
      wr_addr_o  <= wr_addr_nxt;
      wr_data_o  <= wr_data_nxt;
      bit_cnt    <= bit_cnt_nxt;
      rx_shift   <= rx_nxt;
      tx_rest    <= tx_nxt;
      ptr        <= ptr_nxt;
      mack       <= mack_nxt;
    end
  end

  // Register file
  always_ff @(posedge i2c_core_clock_i) begin
    if (!i2c_core_reset_n_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= rx_shift;
    end
  end

endmodule
